// File: rtl/uart_xcvr.sv
// rtl/uart_xcvr.sv - parametrised full-duplex UART transceiver with parity and framing checks
module uart_xcvr #(
  parameter int CLK_FREQ  = 1000000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 newd,
  input  logic [DATA_BITS-1:0] dintx,
  input  logic                 rx,
  output logic                 tx,
  output logic                 busytx,
  output logic                 donetx,
  output logic [DATA_BITS-1:0] doutrx,
  output logic                 donerx,
  output logic                 parity_err,
  output logic                 frame_err
);

  localparam int BIT_CYCLES = CLK_FREQ / BAUD_RATE;
  localparam int CW = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0] BC_LAST   = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CYCLES / 2 - 1);
  localparam logic [3:0]    DB_LAST   = 4'(DATA_BITS - 1);
  localparam logic          SB_LAST   = 1'(STOP_BITS - 1);
  localparam bit            HAS_PAR   = (PARITY != 0);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

  function automatic logic par_of(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~^d : ^d;
  endfunction

  // ---------------- transmitter ----------------
  state_t                 tx_state, tx_state_n;
  logic [CW-1:0]          tx_cnt, tx_cnt_n;
  logic [3:0]             tx_bit, tx_bit_n;
  logic                   tx_stop, tx_stop_n;
  logic [DATA_BITS-1:0]   tx_sh, tx_sh_n;
  logic                   tx_par, tx_par_n;
  logic                   tx_n, busy_n, donetx_n, tx_load, tx_end;

  assign tx_end = (tx_cnt == BC_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_stop  <= 1'b0;
      tx_sh    <= '0;
      tx_par   <= 1'b0;
      tx       <= 1'b1;
      busytx   <= 1'b0;
      donetx   <= 1'b0;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_stop  <= tx_stop_n;
      tx_sh    <= tx_sh_n;
      tx_par   <= tx_par_n;
      tx       <= tx_n;
      busytx   <= busy_n;
      donetx   <= donetx_n;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = (tx_state == S_IDLE || tx_end) ? '0 : tx_cnt + CW'(1);
    tx_bit_n   = tx_bit;
    tx_stop_n  = tx_stop;
    tx_sh_n    = tx_sh;
    tx_par_n   = tx_par;
    tx_n       = tx;
    busy_n     = busytx;
    donetx_n   = 1'b0;
    tx_load    = 1'b0;
    case (tx_state)
      S_IDLE:  tx_load = newd;
      S_START: if (tx_end) begin
        tx_state_n = S_DATA;
        tx_bit_n   = '0;
        tx_n       = tx_sh[0];
      end
      S_DATA: if (tx_end) begin
        tx_sh_n = tx_sh >> 1;
        if (tx_bit == DB_LAST) begin
          if (HAS_PAR) begin
            tx_state_n = S_PARITY;
            tx_n       = tx_par;
          end else begin
            tx_state_n = S_STOP;
            tx_stop_n  = 1'b0;
            tx_n       = 1'b1;
          end
        end else begin
          tx_bit_n = tx_bit + 4'd1;
          tx_n     = tx_sh[1];
        end
      end
      S_PARITY: if (tx_end) begin
        tx_state_n = S_STOP;
        tx_stop_n  = 1'b0;
        tx_n       = 1'b1;
      end
      S_STOP: if (tx_end) begin
        if (tx_stop == SB_LAST) begin
          tx_state_n = S_IDLE;
          busy_n     = 1'b0;
          donetx_n   = 1'b1;
          tx_load    = newd;
        end else begin
          tx_stop_n = 1'b1;
        end
      end
      default: tx_state_n = S_IDLE;
    endcase
    // acceptance in the last stop cycle chains the next frame with no idle gap
    if (tx_load) begin
      tx_state_n = S_START;
      tx_cnt_n   = '0;
      tx_sh_n    = dintx;
      tx_par_n   = par_of(dintx);
      tx_n       = 1'b0;
      busy_n     = 1'b1;
    end
  end

  // ---------------- receiver ----------------
  logic                   rx_m, rx_s, rx_prev;
  state_t                 rx_state, rx_state_n;
  logic [CW-1:0]          rx_cnt, rx_cnt_n;
  logic [3:0]             rx_bit, rx_bit_n;
  logic                   rx_stop, rx_stop_n;
  logic [DATA_BITS-1:0]   rx_sh, rx_sh_n;
  logic                   rx_par, rx_par_n;
  logic                   rx_ferr, rx_ferr_n;
  logic [DATA_BITS-1:0]   doutrx_n;
  logic                   donerx_n, parity_err_n, frame_err_n, rx_samp;

  // rx_prev clears on reset so a line must be seen high before a start edge counts
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_m       <= 1'b1;
      rx_s       <= 1'b1;
      rx_prev    <= 1'b0;
      rx_state   <= S_IDLE;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_stop    <= 1'b0;
      rx_sh      <= '0;
      rx_par     <= 1'b0;
      rx_ferr    <= 1'b0;
      doutrx     <= '0;
      donerx     <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_m       <= rx;
      rx_s       <= rx_m;
      rx_prev    <= rx_s;
      rx_state   <= rx_state_n;
      rx_cnt     <= rx_cnt_n;
      rx_bit     <= rx_bit_n;
      rx_stop    <= rx_stop_n;
      rx_sh      <= rx_sh_n;
      rx_par     <= rx_par_n;
      rx_ferr    <= rx_ferr_n;
      doutrx     <= doutrx_n;
      donerx     <= donerx_n;
      parity_err <= parity_err_n;
      frame_err  <= frame_err_n;
    end
  end

  assign rx_samp = (rx_state == S_START) ? (rx_cnt == HALF_LAST) : (rx_cnt == BC_LAST);

  always_comb begin
    rx_state_n   = rx_state;
    rx_cnt_n     = (rx_state == S_IDLE || rx_state == S_BREAK || rx_samp) ? '0 : rx_cnt + CW'(1);
    rx_bit_n     = rx_bit;
    rx_stop_n    = rx_stop;
    rx_sh_n      = rx_sh;
    rx_par_n     = rx_par;
    rx_ferr_n    = rx_ferr;
    doutrx_n     = doutrx;
    donerx_n     = 1'b0;
    parity_err_n = parity_err;
    frame_err_n  = frame_err;
    case (rx_state)
      S_IDLE: if (!rx_s && rx_prev) rx_state_n = S_START;
      S_START: if (rx_samp) begin
        rx_state_n = rx_s ? S_IDLE : S_DATA;
        rx_bit_n   = '0;
      end
      S_DATA: if (rx_samp) begin
        rx_sh_n = {rx_s, rx_sh[DATA_BITS-1:1]};
        if (rx_bit == DB_LAST) begin
          rx_state_n = HAS_PAR ? S_PARITY : S_STOP;
          rx_stop_n  = 1'b0;
          rx_ferr_n  = 1'b0;
        end else begin
          rx_bit_n = rx_bit + 4'd1;
        end
      end
      S_PARITY: if (rx_samp) begin
        rx_par_n   = rx_s;
        rx_state_n = S_STOP;
      end
      S_STOP: if (rx_samp) begin
        if (!rx_s) rx_ferr_n = 1'b1;
        if (rx_stop == SB_LAST) begin
          doutrx_n     = rx_sh;
          parity_err_n = HAS_PAR && (rx_par != par_of(rx_sh));
          frame_err_n  = rx_ferr | !rx_s;
          donerx_n     = 1'b1;
          rx_state_n   = rx_s ? S_IDLE : S_BREAK;
        end else begin
          rx_stop_n = 1'b1;
        end
      end
      S_BREAK: if (rx_s) rx_state_n = S_IDLE;
      default: rx_state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_xcvr.sv
// tb/tb_uart_xcvr.sv - randomized self-checking bench for uart_xcvr (8N1, 7E2, 8O1 instances)
module tb_uart_xcvr;
  localparam int BC = 104;
  localparam int DB_T[3]  = '{8, 7, 8};
  localparam int PAR_T[3] = '{0, 2, 1};
  localparam int SB_T[3]  = '{1, 2, 1};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [2:0] newd = 3'b000;
  logic [2:0] lb = 3'b000;
  logic [2:0] drv = 3'b111;
  logic [8:0] din = '0;
  wire  [2:0] txw, busyw, dtxw, drxw, perrw, ferrw;
  wire  [2:0] rxw = (lb & txw) | (~lb & drv);
  wire  [7:0] dout0, dout2;
  wire  [6:0] dout1;
  logic [8:0] doutv[3];
  int n_cmp = 0;
  int n_err = 0;
  int txcnt[3] = '{0, 0, 0};
  int rxcnt[3] = '{0, 0, 0};

  always #5 clk = ~clk;

  always_comb begin
    doutv[0] = {1'b0, dout0};
    doutv[1] = {2'b00, dout1};
    doutv[2] = {1'b0, dout2};
  end

  always @(negedge clk)
    for (int i = 0; i < 3; i++) begin
      if (dtxw[i]) txcnt[i]++;
      if (drxw[i]) rxcnt[i]++;
    end

  uart_xcvr #(.CLK_FREQ(1000000), .BAUD_RATE(9600), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) d0 (
    .clk(clk), .rst(rst), .newd(newd[0]), .dintx(din[7:0]), .rx(rxw[0]), .tx(txw[0]),
    .busytx(busyw[0]), .donetx(dtxw[0]), .doutrx(dout0), .donerx(drxw[0]),
    .parity_err(perrw[0]), .frame_err(ferrw[0]));
  uart_xcvr #(.CLK_FREQ(1000000), .BAUD_RATE(9600), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) d1 (
    .clk(clk), .rst(rst), .newd(newd[1]), .dintx(din[6:0]), .rx(rxw[1]), .tx(txw[1]),
    .busytx(busyw[1]), .donetx(dtxw[1]), .doutrx(dout1), .donerx(drxw[1]),
    .parity_err(perrw[1]), .frame_err(ferrw[1]));
  uart_xcvr #(.CLK_FREQ(1000000), .BAUD_RATE(9600), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) d2 (
    .clk(clk), .rst(rst), .newd(newd[2]), .dintx(din[7:0]), .rx(rxw[2]), .tx(txw[2]),
    .busytx(busyw[2]), .donetx(dtxw[2]), .doutrx(dout2), .donerx(drxw[2]),
    .parity_err(perrw[2]), .frame_err(ferrw[2]));

  // reference line image of one frame, built from the framing rules
  task automatic make_frame(input int sel, input int data, input bit flip, input bit stop_low,
                            output logic [15:0] bits, output int nb);
    int ones;
    int k;
    logic p;
    bits = '1;
    ones = 0;
    bits[0] = 1'b0;
    for (int i = 0; i < DB_T[sel]; i++) begin
      bits[1+i] = data[i];
      ones += int'(data[i]);
    end
    k = 1 + DB_T[sel];
    if (PAR_T[sel] != 0) begin
      p = (ones % 2) == 1;
      if (PAR_T[sel] == 1) p = ~p;
      bits[k] = p ^ flip;
      k++;
    end
    for (int i = 0; i < SB_T[sel]; i++) begin
      bits[k] = ~stop_low;
      k++;
    end
    nb = k;
  endtask

  function automatic int rnd(input int sel);
    return int'($urandom) & ((1 << DB_T[sel]) - 1);
  endfunction

  task automatic tx_frame(input int sel, input int data, input bit started, input bit chain,
                          input int next_data, input bit poke);
    logic [15:0] bits;
    int nb, n, t, r0, target;
    make_frame(sel, data, 1'b0, 1'b0, bits, nb);
    n = nb * BC;
    r0 = rxcnt[sel];
    if (!started) begin
      din = 9'(data);
      newd[sel] = 1'b1;
      @(negedge clk);
      newd[sel] = 1'b0;
    end
    t = 0;
    n_cmp++;
    if (txw[sel] !== 1'b0 || busyw[sel] !== 1'b1) begin
      n_err++;
      $display("FAIL tx_accept sel=%0d tx=%b busy=%b required tx=0 busy=1", sel, txw[sel], busyw[sel]);
    end
    for (int i = 0; i < nb; i++) begin
      target = i * BC + BC / 2;
      repeat (target - t) @(negedge clk);
      t = target;
      n_cmp++;
      if (txw[sel] !== bits[i] || busyw[sel] !== 1'b1 || dtxw[sel] !== 1'b0) begin
        n_err++;
        $display("FAIL tx_bit sel=%0d bit=%0d tx=%b busy=%b done=%b required tx=%b busy=1 done=0",
                 sel, i, txw[sel], busyw[sel], dtxw[sel], bits[i]);
      end
      if (poke && i == 3) begin
        din = ~9'(data);
        newd[sel] = 1'b1;
        @(negedge clk);
        t++;
        newd[sel] = 1'b0;
      end
    end
    repeat (n - 1 - t) @(negedge clk);
    n_cmp++;
    if (busyw[sel] !== 1'b1 || dtxw[sel] !== 1'b0) begin
      n_err++;
      $display("FAIL tx_last_cycle sel=%0d busy=%b done=%b required busy=1 done=0", sel, busyw[sel], dtxw[sel]);
    end
    if (chain) begin
      din = 9'(next_data);
      newd[sel] = 1'b1;
    end
    @(negedge clk);
    newd[sel] = 1'b0;
    n_cmp++;
    if (dtxw[sel] !== 1'b1 || busyw[sel] !== chain || txw[sel] !== !chain) begin
      n_err++;
      $display("FAIL tx_end sel=%0d done=%b busy=%b tx=%b required done=1 busy=%b tx=%b",
               sel, dtxw[sel], busyw[sel], txw[sel], chain, !chain);
    end
    if (lb[sel]) begin
      n_cmp++;
      if (rxcnt[sel] - r0 != 1 || doutv[sel] !== 9'(data) || perrw[sel] !== 1'b0 || ferrw[sel] !== 1'b0) begin
        n_err++;
        $display("FAIL loopback sel=%0d pulses=%0d dout=%h perr=%b ferr=%b required 1 %h 0 0",
                 sel, rxcnt[sel] - r0, doutv[sel], perrw[sel], ferrw[sel], 9'(data));
      end
    end
  endtask

  task automatic drive_rx(input int sel, input int data, input bit flip, input bit stop_low);
    logic [15:0] bits;
    int nb;
    make_frame(sel, data, flip, stop_low, bits, nb);
    for (int i = 0; i < nb; i++) begin
      drv[sel] = bits[i];
      repeat (BC) @(negedge clk);
    end
    if (!stop_low) drv[sel] = 1'b1;
  endtask

  task automatic check_rx(input string name, input int sel, input int pulses, input int data,
                          input logic perr, input logic ferr);
    n_cmp++;
    if (pulses != 1 || doutv[sel] !== 9'(data) || perrw[sel] !== perr || ferrw[sel] !== ferr) begin
      n_err++;
      $display("FAIL %s sel=%0d pulses=%0d dout=%h perr=%b ferr=%b required 1 %h %b %b",
               name, sel, pulses, doutv[sel], perrw[sel], ferrw[sel], 9'(data), perr, ferr);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (txw !== 3'b111 || busyw !== 3'b000 || dtxw !== 3'b000 || drxw !== 3'b000 ||
        perrw !== 3'b000 || ferrw !== 3'b000) begin
      n_err++;
      $display("FAIL reset_outputs tx=%b busy=%b dtx=%b drx=%b perr=%b ferr=%b required 111 000 000 000 000 000",
               txw, busyw, dtxw, drxw, perrw, ferrw);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (doutv[i] !== 9'd0) begin
        n_err++;
        $display("FAIL reset_dout sel=%0d dout=%h required 0", i, doutv[i]);
      end
    end
    rst = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_loopback();
    lb = 3'b111;
    tx_frame(0, 'hA5, 1'b0, 1'b0, 0, 1'b0);
    tx_frame(1, 'h07, 1'b0, 1'b0, 0, 1'b0);
    for (int r = 0; r < 3; r++)
      for (int s = 0; s < 3; s++) tx_frame(s, rnd(s), 1'b0, 1'b0, 0, 1'b0);
    lb = 3'b000;
    repeat (BC) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int a, b;
    a = rnd(0);
    b = rnd(0);
    lb[0] = 1'b1;
    tx_frame(0, a, 1'b0, 1'b1, b, 1'b0);
    tx_frame(0, b, 1'b1, 1'b0, 0, 1'b0);
    tx_frame(0, rnd(0), 1'b0, 1'b0, 0, 1'b1);
    lb[0] = 1'b0;
    repeat (BC) @(negedge clk);
  endtask

  task automatic test_parity();
    int r0, d;
    r0 = rxcnt[2];
    drive_rx(2, 'h3C, 1'b1, 1'b0);
    repeat (BC) @(negedge clk);
    check_rx("odd_parity_bad", 2, rxcnt[2] - r0, 'h3C, 1'b1, 1'b0);
    d = rnd(2);
    r0 = rxcnt[2];
    drive_rx(2, d, 1'b0, 1'b0);
    repeat (BC) @(negedge clk);
    check_rx("odd_parity_clear", 2, rxcnt[2] - r0, d, 1'b0, 1'b0);
    d = rnd(1);
    r0 = rxcnt[1];
    drive_rx(1, d, 1'b1, 1'b0);
    repeat (BC) @(negedge clk);
    check_rx("even_parity_bad", 1, rxcnt[1] - r0, d, 1'b1, 1'b0);
  endtask

  task automatic test_break();
    int r0, d;
    d = rnd(0);
    r0 = rxcnt[0];
    drive_rx(0, d, 1'b0, 1'b1);
    repeat (3000) @(negedge clk);
    check_rx("break_frame", 0, rxcnt[0] - r0, d, 1'b0, 1'b1);
    drv[0] = 1'b1;
    repeat (3 * BC) @(negedge clk);
    n_cmp++;
    if (rxcnt[0] - r0 != 1) begin
      n_err++;
      $display("FAIL break_single pulses=%0d required 1", rxcnt[0] - r0);
    end
    d = rnd(0);
    r0 = rxcnt[0];
    drive_rx(0, d, 1'b0, 1'b0);
    repeat (BC) @(negedge clk);
    check_rx("after_break", 0, rxcnt[0] - r0, d, 1'b0, 1'b0);
  endtask

  task automatic test_glitch();
    int r0, d;
    logic [8:0] keep;
    r0 = rxcnt[0];
    keep = doutv[0];
    drv[0] = 1'b0;
    repeat (20) @(negedge clk);
    drv[0] = 1'b1;
    repeat (300) @(negedge clk);
    n_cmp++;
    if (rxcnt[0] != r0 || doutv[0] !== keep || perrw[0] !== 1'b0 || ferrw[0] !== 1'b0) begin
      n_err++;
      $display("FAIL glitch pulses=%0d dout=%h ferr=%b required 0 %h 0", rxcnt[0] - r0, doutv[0], ferrw[0], keep);
    end
    d = rnd(0);
    r0 = rxcnt[0];
    drive_rx(0, d, 1'b0, 1'b0);
    repeat (BC) @(negedge clk);
    check_rx("after_glitch", 0, rxcnt[0] - r0, d, 1'b0, 1'b0);
  endtask

  task automatic test_reset_midframe();
    int t0, r0;
    lb[0] = 1'b1;
    t0 = txcnt[0];
    r0 = rxcnt[0];
    din = 9'(rnd(0));
    newd[0] = 1'b1;
    @(negedge clk);
    newd[0] = 1'b0;
    repeat (4 * BC + BC / 2) @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (txw[0] !== 1'b1 || busyw[0] !== 1'b0 || doutv[0] !== 9'd0) begin
      n_err++;
      $display("FAIL reset_abort tx=%b busy=%b dout=%h required 1 0 0", txw[0], busyw[0], doutv[0]);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (12 * BC) @(negedge clk);
    n_cmp++;
    if (txcnt[0] != t0 || rxcnt[0] != r0 || txw[0] !== 1'b1 || busyw[0] !== 1'b0) begin
      n_err++;
      $display("FAIL reset_no_done dtx=%0d drx=%0d tx=%b busy=%b required 0 0 1 0",
               txcnt[0] - t0, rxcnt[0] - r0, txw[0], busyw[0]);
    end
    tx_frame(0, rnd(0), 1'b0, 1'b0, 0, 1'b0);
    lb[0] = 1'b0;
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_back_to_back();
    test_parity();
    test_break();
    test_glitch();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule

// File: doc/uart_xcvr.md
# uart_xcvr

Parametrised full-duplex UART transceiver: one transmitter and one receiver sharing a single system clock, with configurable data width, parity mode and stop-bit count. Both directions use clock-enable counters instead of derived clocks. The receiver samples at mid-bit, validates the start bit and reports parity and framing errors. It replaces the fixed 8N1 transceiver in designs that need non-8N1 framing or error reporting.

## Interface
- CLK_FREQ, 1000000: system clock frequency in Hz.
- BAUD_RATE, 9600: line rate. BIT_CYCLES = CLK_FREQ/BAUD_RATE (integer division), must be ≥ 4.
- DATA_BITS, 8: payload bits per frame, legal range 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- newd  in  1  transmit request, sampled each clk.
- dintx  in  DATA_BITS  transmit payload, captured when the request is accepted.
- rx  in  1  serial input, asynchronous to clk.
- tx  out  1  serial output, idle high.
- busytx  out  1  transmitter is sending a frame.
- donetx  out  1  one-cycle pulse when a frame finishes.
- doutrx  out  DATA_BITS  last received payload.
- donerx  out  1  one-cycle pulse when a frame is received.
- parity_err  out  1  parity mismatch on the last frame. Constant 0 when PARITY = 0.
- frame_err  out  1  a stop bit was sampled low on the last frame.

## Operation
- Reset (rst = 0) forces outputs immediately: tx = 1, busytx = 0, donetx = 0, doutrx = 0, donerx = 0, parity_err = 0, frame_err = 0. Both FSMs go to IDLE, all counters clear and the rx synchroniser presets to 1.
- Frame format: start bit (0), then DATA_BITS bits LSB first, then the parity bit if PARITY ≠ 0, then STOP_BITS stop bits (1).
- Parity bit: even mode drives the XOR of the data bits; odd mode drives its inverse.
- TX FSM states: IDLE → START → DATA → PARITY (skipped when PARITY = 0) → STOP → IDLE.
  - In IDLE with newd = 1, the FSM captures dintx, drives tx = 0 and sets busytx = 1.
  - newd is ignored whenever busytx = 1. No queueing.
  - A bit counter tracks DATA bits. A stop counter tracks STOP bits.
- RX input: rx passes through a 2-flop synchroniser to give rx_s. A falling edge is detected as rx_s = 0 with the previous rx_s = 1.
- RX FSM states: IDLE → START → DATA → PARITY (skipped when PARITY = 0) → STOP → IDLE, plus a BREAK state.
  - START: checks rx_s at BIT_CYCLES/2 after the edge. If rx_s = 1 the start was a glitch: return to IDLE with no pulse and no flag change.
  - DATA, PARITY and STOP: each bit is sampled every BIT_CYCLES after the start-bit check.
  - At the last stop-bit sample: update doutrx, parity_err and frame_err, and pulse donerx. This happens even when an error is flagged.
  - Error flags hold until the next donerx.
  - If frame_err = 1 and rx_s = 0 at the last stop sample, go to BREAK. Leave BREAK only when rx_s = 1, so a held-low line produces exactly one frame.
- TX and RX are fully independent and may run at the same time.

## Timing
- TX acceptance edge E: tx is low and busytx is high immediately after E.
- Each tx bit is held for exactly BIT_CYCLES clocks.
- Frame length N = (1 + DATA_BITS + (PARITY ≠ 0) + STOP_BITS) × BIT_CYCLES clocks.
- At edge E + N: busytx falls and donetx = 1 for one cycle. newd is acceptable on that same edge, giving back-to-back frames with no idle gap.
- RX latency: synchroniser adds 2 clocks. Then the start sample comes BIT_CYCLES/2 after the detected edge, and each later sample follows BIT_CYCLES after the previous one.
- donerx asserts on the edge after the final stop-bit sample.
- Reset asserted mid-frame aborts both directions immediately, with no donetx or donerx. After reset is released, the receiver needs rx_s to be seen high before it can detect a new start bit.

## Test plan
- Loopback, defaults (8N1, BIT_CYCLES = 104): send dintx = 0xA5 → tx pattern 0,1,0,1,0,0,1,0,1,1. Frame is 1040 clocks. donetx and donerx each pulse once, doutrx = 0xA5, both error flags 0.
- PARITY = 2, DATA_BITS = 7, STOP_BITS = 2: send 0x07 → parity bit 1, frame 11 × 104 clocks. Loopback gives doutrx = 0x07.
- PARITY = 1: drive rx with 0x3C and a wrong parity bit → donerx pulses, doutrx = 0x3C, parity_err = 1. The next good frame clears it.
- Drive a frame with the stop bit low, then hold rx low for 3000 clocks → exactly one donerx with frame_err = 1. No further frames until rx returns high.
- rx low pulse of 20 clocks → no donerx and no flag change. A valid frame sent afterwards is received correctly.
- Assert newd during a busy frame → ignored, tx pattern unchanged. Assert rst at bit 4 of a frame → tx = 1 and busytx = 0 immediately, and no donetx is ever produced for that frame.
